eth_axis_frame_fifo: RTL

Single-clock, store-and-forward AXI-Stream frame FIFO for the Ethernet MAC datapath. It is generalised in data width (with tkeep), depth and drop policy. It adds saturating good/bad/overflow frame counters and a committed-occupancy output. It sits between logic-domain DMA/CPU stream ports and the MAC-side async FIFOs, buffering whole frames so that bad frames never reach downstream.

---
 rtl/eth_fifo_pkg.sv | 22 ++
 rtl/eth_fifo_sdp_ram.sv | 26 ++
 rtl/eth_axis_frame_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_fifo_pkg.sv
// Shared types and helpers for the store-and-forward Ethernet frame FIFO.
package eth_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP
    } wr_state_t;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Saturating increment for counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/eth_fifo_sdp_ram.sv
// Simple dual-port RAM with a registered, enabled read port; the array has no reset.
module eth_fifo_sdp_ram #(
    parameter int WIDTH      = 10,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_axis_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO: frames become visible downstream only
// once their last beat is accepted, and bad or oversized frames are discarded.
module eth_axis_frame_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_WIDTH     = DATA_WIDTH/8,
    parameter int ADDR_WIDTH     = 12,
    parameter int DROP_BAD_FRAME = 1,
    parameter int DROP_WHEN_FULL = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  logic_clk,
    input  logic                  logic_rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  stat_clear,
    output logic [CNT_WIDTH-1:0]  stat_good_frames,
    output logic [CNT_WIDTH-1:0]  stat_bad_frames,
    output logic [CNT_WIDTH-1:0]  stat_overflow_frames,
    output logic                  status_overflow,
    output logic                  status_bad_frame,
    output logic                  status_good_frame,
    output logic [ADDR_WIDTH:0]   status_depth
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam int RAM_W = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PTR_W-1:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    wr_state_t        state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_cur_reg, wr_ptr_cur_next;
    logic [PTR_W-1:0] wr_ptr_commit_reg, wr_ptr_commit_next;
    logic [PTR_W-1:0] rd_ptr_reg, fetch_ptr_reg;
    logic             full, drop_on_full, s_accept, ram_we;
    logic             good_evt, bad_evt, ovf_evt;
    logic             ram_valid_reg, out_ready, ram_pop, rd_en, m_pop, fetch_empty;
    logic [RAM_W-1:0] ram_wr_data, ram_rd_data;
    logic [2:0]       evt;

    // rd_ptr counts words that have left m_axis, so occupancy includes the read pipeline.
    assign full          = (wr_ptr_cur_reg - rd_ptr_reg) == CAPACITY;
    assign drop_on_full  = (DROP_WHEN_FULL != 0) || (wr_ptr_commit_reg == rd_ptr_reg);
    assign s_axis_tready = !full || (state_reg == DROP) || (DROP_WHEN_FULL != 0);
    assign s_accept      = s_axis_tvalid && s_axis_tready;
    assign ram_wr_data   = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            state_reg         <= IDLE;
            wr_ptr_cur_reg    <= '0;
            wr_ptr_commit_reg <= '0;
            status_good_frame <= 1'b0;
            status_bad_frame  <= 1'b0;
            status_overflow   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            wr_ptr_cur_reg    <= wr_ptr_cur_next;
            wr_ptr_commit_reg <= wr_ptr_commit_next;
            status_good_frame <= good_evt;
            status_bad_frame  <= bad_evt;
            status_overflow   <= ovf_evt;
        end
    end

    always_comb begin
        state_next         = state_reg;
        wr_ptr_cur_next    = wr_ptr_cur_reg;
        wr_ptr_commit_next = wr_ptr_commit_reg;
        ram_we             = 1'b0;
        good_evt           = 1'b0;
        bad_evt            = 1'b0;
        ovf_evt            = 1'b0;
        case (state_reg)
            IDLE, FRAME: begin
                if (full) begin
                    if (state_reg == FRAME && drop_on_full) begin
                        wr_ptr_cur_next = wr_ptr_commit_reg;
                        if (s_accept && s_axis_tlast) begin
                            state_next = IDLE;
                            ovf_evt    = 1'b1;
                        end else begin
                            state_next = DROP;
                        end
                    end else if (state_reg == IDLE && s_accept) begin
                        // A new frame arriving with no room at all (drop-when-full only).
                        if (s_axis_tlast) begin
                            ovf_evt = 1'b1;
                        end else begin
                            state_next = DROP;
                        end
                    end
                end else if (s_accept) begin
                    ram_we          = 1'b1;
                    wr_ptr_cur_next = wr_ptr_cur_reg + PTR_W'(1);
                    if (s_axis_tlast) begin
                        state_next = IDLE;
                        if (s_axis_tuser && (DROP_BAD_FRAME != 0)) begin
                            wr_ptr_cur_next = wr_ptr_commit_reg;
                            bad_evt         = 1'b1;
                        end else begin
                            wr_ptr_commit_next = wr_ptr_cur_reg + PTR_W'(1);
                            good_evt           = 1'b1;
                        end
                    end else begin
                        state_next = FRAME;
                    end
                end
            end
            DROP: begin
                if (s_accept && s_axis_tlast) begin
                    state_next = IDLE;
                    ovf_evt    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    eth_fifo_sdp_ram #(
        .WIDTH      (RAM_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (logic_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_cur_reg[ADDR_WIDTH-1:0]),
        .wr_data (ram_wr_data),
        .rd_en   (rd_en),
        .rd_addr (fetch_ptr_reg[ADDR_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // Two-stage read pipeline (RAM register, output register) that streams without bubbles.
    assign fetch_empty = fetch_ptr_reg == wr_ptr_commit_reg;
    assign out_ready   = !m_axis_tvalid || m_axis_tready;
    assign ram_pop     = ram_valid_reg && out_ready;
    assign rd_en       = !fetch_empty && (!ram_valid_reg || ram_pop);
    assign m_pop       = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge logic_clk or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            fetch_ptr_reg <= '0;
            rd_ptr_reg    <= '0;
            ram_valid_reg <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (rd_en) begin
                fetch_ptr_reg <= fetch_ptr_reg + PTR_W'(1);
            end
            if (m_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                ram_valid_reg <= 1'b1;
            end else if (ram_pop) begin
                ram_valid_reg <= 1'b0;
            end
            if (out_ready) begin
                m_axis_tvalid <= ram_valid_reg;
                if (ram_valid_reg) begin
                    {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_rd_data;
                end
            end
        end
    end

    assign m_axis_tuser = 1'b0;
    assign status_depth = wr_ptr_commit_reg - rd_ptr_reg;

    assign evt = {ovf_evt, bad_evt, good_evt};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            always_ff @(posedge logic_clk or negedge logic_rst_n) begin
                if (!logic_rst_n) begin
                    cnt_reg <= '0;
                end else if (stat_clear) begin
                    cnt_reg <= evt[gi] ? CNT_WIDTH'(1) : '0;
                end else if (evt[gi]) begin
                    cnt_reg <= CNT_WIDTH'(sat_inc(32'(cnt_reg), CNT_WIDTH));
                end
            end
        end
    endgenerate

    assign stat_good_frames     = g_cnt[0].cnt_reg;
    assign stat_bad_frames      = g_cnt[1].cnt_reg;
    assign stat_overflow_frames = g_cnt[2].cnt_reg;

endmodule
